// File: rtl/sys_timer_pkg.sv
// Shared register map, CTRL bit positions and prescaler encoding for the
// multi-channel system timer.
package sys_timer_pkg;

  localparam logic [1:0] OFS_RLO  = 2'd0;
  localparam logic [1:0] OFS_RHI  = 2'd1;
  localparam logic [1:0] OFS_CTRL = 2'd2;
  localparam logic [1:0] OFS_STAT = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int CTRL_PS_LSB = 4;

  typedef enum logic [1:0] {
    PS_DIV1   = 2'd0,
    PS_DIV16  = 2'd1,
    PS_DIV64  = 2'd2,
    PS_DIV256 = 2'd3
  } ps_e;

  // Number of low prescaler bits that must all be ones to produce a tick.
  function automatic logic [3:0] psTickWidth(input ps_e ps);
    case (ps)
      PS_DIV1:  return 4'd0;
      PS_DIV16: return 4'd4;
      PS_DIV64: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sys_timer_if.sv
// System-register bus bundle between the CPU side and the timer block.
interface sys_timer_if;
  logic       sys_cs;
  logic       cpu_rwn;
  logic [6:0] AB;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output sys_cs, cpu_rwn, AB, din, input dout, irq);
  modport slave  (input sys_cs, cpu_rwn, AB, din, output dout, irq);
endinterface

// File: rtl/sys_timer_chan.sv
// One timer channel: reload/control registers, 8-bit prescaler, down-counter
// and sticky interrupt flag.
module sys_timer_chan
  import sys_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_i,
  input  logic       wrRlo_i,
  input  logic       wrRhi_i,
  input  logic       wrCtrl_i,
  input  logic       wrStat_i,
  input  logic [7:0] din_i,
  output logic [7:0] rdRlo_o,
  output logic [7:0] rdRhi_o,
  output logic [7:0] rdCtrl_o,
  output logic [7:0] rdStat_o,
  output logic       irqReq_o
);

  localparam int STAT_LSB = (CNT_W == 8) ? 0 : 2;
  localparam bit HAS_HI   = (CNT_W > 8);

  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       presc_q, presc_d;
  logic             en_q, en_d;
  logic             irqEn_q, irqEn_d;
  logic             auto_q, auto_d;
  logic             flag_q, flag_d;
  ps_e              ps_q, ps_d;

  logic [7:0]  tickMask;
  logic        disableWr;
  logic        rhiWr;
  logic        tick;
  logic [15:0] reloadWide;
  logic [15:0] reloadNew;

  assign tickMask   = 8'hFF >> (4'd8 - psTickWidth(ps_q));
  assign disableWr  = wrCtrl_i & ~din_i[CTRL_EN];
  assign rhiWr      = wrRhi_i & HAS_HI;
  // A disabling CTRL write on the tick edge suppresses the tick entirely.
  assign tick       = ce_i & en_q & ((presc_q & tickMask) == tickMask) & ~disableWr;
  assign reloadWide = 16'(reload_q);

  always_comb begin
    reloadNew = reloadWide;
    if (wrRlo_i) reloadNew[7:0] = din_i;
    if (rhiWr) reloadNew[15:8] = din_i;
  end

  always_comb begin
    reload_d = reloadNew[CNT_W-1:0];
    count_d  = count_q;
    presc_d  = presc_q;
    en_d     = en_q;
    irqEn_d  = irqEn_q;
    auto_d   = auto_q;
    flag_d   = flag_q;
    ps_d     = ps_q;

    if (wrStat_i && din_i[0]) flag_d = 1'b0;

    if (ce_i && en_q && !disableWr) presc_d = presc_q + 8'd1;

    // Underflow sets the flag after any W1C above, so set wins.
    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        flag_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end
    end

    if ((wrRlo_i || rhiWr) && !en_q) count_d = reloadNew[CNT_W-1:0];

    if (wrCtrl_i) begin
      en_d    = din_i[CTRL_EN];
      irqEn_d = din_i[CTRL_IRQ_EN];
      auto_d  = din_i[CTRL_AUTO];
      ps_d    = ps_e'(din_i[CTRL_PS_LSB +: 2]);
      // An enabling write restarts the count, including over a one-shot expiry.
      if (din_i[CTRL_EN] && !en_q) begin
        count_d = reload_q;
        presc_d = 8'd0;
      end else if (din_i[CTRL_EN] && tick && count_q == '0 && !auto_q) begin
        count_d = reload_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= 8'd0;
      en_q     <= 1'b0;
      irqEn_q  <= 1'b0;
      auto_q   <= 1'b0;
      flag_q   <= 1'b0;
      ps_q     <= PS_DIV1;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      irqEn_q  <= irqEn_d;
      auto_q   <= auto_d;
      flag_q   <= flag_d;
      ps_q     <= ps_d;
    end
  end

  assign rdRlo_o  = reloadWide[7:0];
  assign rdRhi_o  = reloadWide[15:8];
  assign rdCtrl_o = {2'b00, ps_q, 1'b0, auto_q, irqEn_q, en_q};
  assign rdStat_o = {count_q[STAT_LSB +: 6], en_q, flag_q};
  assign irqReq_o = flag_q & irqEn_q;

endmodule

// File: rtl/sys_timer.sv
// Multi-channel programmable interval timer on the system-register bus:
// address decode, channel array, read mux and combined interrupt.
module sys_timer
  import sys_timer_pkg::*;
#(
  parameter int         NUM_CH = 2,
  parameter int         CNT_W  = 8,
  parameter logic [6:0] BASE   = 7'h30
) (
  input logic       clk,
  input logic       reset_n,
  input logic       ce,
  sys_timer_if.slave bus
);

  localparam logic [7:0] SPAN = 8'(4 * NUM_CH);

  logic [7:0]        relAddr;
  logic              inRange;
  logic              wrStrobe;
  logic [5:0]        chSel;
  logic [1:0]        regOfs;
  logic [7:0]        doutMux;
  logic [NUM_CH-1:0] irqReq;
  logic [7:0]        rdRlo  [NUM_CH];
  logic [7:0]        rdRhi  [NUM_CH];
  logic [7:0]        rdCtrl [NUM_CH];
  logic [7:0]        rdStat [NUM_CH];

  assign relAddr  = {1'b0, bus.AB} - {1'b0, BASE};
  assign inRange  = (bus.AB >= BASE) && (relAddr < SPAN);
  assign chSel    = relAddr[7:2];
  assign regOfs   = relAddr[1:0];
  assign wrStrobe = bus.sys_cs & ~bus.cpu_rwn & ce & inRange;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic chWr;
    assign chWr = wrStrobe && (chSel == 6'(g));

    sys_timer_chan #(.CNT_W(CNT_W)) uChan (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce_i     (ce),
      .wrRlo_i  (chWr && (regOfs == OFS_RLO)),
      .wrRhi_i  (chWr && (regOfs == OFS_RHI)),
      .wrCtrl_i (chWr && (regOfs == OFS_CTRL)),
      .wrStat_i (chWr && (regOfs == OFS_STAT)),
      .din_i    (bus.din),
      .rdRlo_o  (rdRlo[g]),
      .rdRhi_o  (rdRhi[g]),
      .rdCtrl_o (rdCtrl[g]),
      .rdStat_o (rdStat[g]),
      .irqReq_o (irqReq[g])
    );
  end

  always_comb begin
    doutMux = 8'h00;
    if (bus.sys_cs && inRange) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (chSel == 6'(i)) begin
          case (regOfs)
            OFS_RLO:  doutMux = rdRlo[i];
            OFS_RHI:  doutMux = rdRhi[i];
            OFS_CTRL: doutMux = rdCtrl[i];
            default:  doutMux = rdStat[i];
          endcase
        end
      end
    end
  end

  assign bus.dout = doutMux;
  assign bus.irq  = |irqReq;

endmodule

// File: tb/tb_sys_timer.sv
// Directed self-checking bench for sys_timer: an 8-bit two-channel instance
// and a 16-bit single-channel instance on separate buses and resets.
module tb_sys_timer;

  logic clk;
  logic rstN8, rstN16;
  logic ce8, ce16;
  int   checks;
  int   failures;

  sys_timer_if bus8 ();
  sys_timer_if bus16 ();

  sys_timer #(.NUM_CH(2), .CNT_W(8), .BASE(7'h30)) dut8 (
    .clk     (clk),
    .reset_n (rstN8),
    .ce      (ce8),
    .bus     (bus8)
  );

  sys_timer #(.NUM_CH(1), .CNT_W(16), .BASE(7'h30)) dut16 (
    .clk     (clk),
    .reset_n (rstN16),
    .ce      (ce16),
    .bus     (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit use16, input logic [6:0] addr,
                               input logic [7:0] data);
    if (use16) begin
      bus16.sys_cs = 1'b1; bus16.cpu_rwn = 1'b0; bus16.AB = addr; bus16.din = data;
    end else begin
      bus8.sys_cs = 1'b1; bus8.cpu_rwn = 1'b0; bus8.AB = addr; bus8.din = data;
    end
    @(posedge clk);
    #1;
    bus8.sys_cs = 1'b0; bus8.cpu_rwn = 1'b1;
    bus16.sys_cs = 1'b0; bus16.cpu_rwn = 1'b1;
  endtask

  task automatic readReg(input bit use16, input logic [6:0] addr,
                         output logic [7:0] data);
    if (use16) begin
      bus16.sys_cs = 1'b1; bus16.cpu_rwn = 1'b1; bus16.AB = addr;
    end else begin
      bus8.sys_cs = 1'b1; bus8.cpu_rwn = 1'b1; bus8.AB = addr;
    end
    #1;
    data = use16 ? bus16.dout : bus8.dout;
    bus8.sys_cs = 1'b0;
    bus16.sys_cs = 1'b0;
  endtask

  task automatic checkReg(input bit use16, input logic [6:0] addr,
                          input logic [7:0] expected, input string tag);
    logic [7:0] data;
    readReg(use16, addr, data);
    checkOutput(tag, data, expected);
  endtask

  task automatic checkIrq(input bit use16, input logic expected, input string tag);
    checkOutput(tag, {7'b0, (use16 ? bus16.irq : bus8.irq)}, {7'b0, expected});
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstN8 = 1'b0; rstN16 = 1'b0;
    ce8 = 1'b1; ce16 = 1'b1;
    bus8.sys_cs = 1'b0;  bus8.cpu_rwn = 1'b1;  bus8.AB = 7'h0;  bus8.din = 8'h0;
    bus16.sys_cs = 1'b0; bus16.cpu_rwn = 1'b1; bus16.AB = 7'h0; bus16.din = 8'h0;
    #12;
    rstN8 = 1'b1; rstN16 = 1'b1;
    waitEdges(1);

    $display("[TB] reset state");
    for (int a = 'h30; a < 'h38; a++)
      checkReg(1'b0, 7'(a), 8'h00, $sformatf("rst8 addr %h", a));
    for (int a = 'h30; a < 'h34; a++)
      checkReg(1'b1, 7'(a), 8'h00, $sformatf("rst16 addr %h", a));
    checkReg(1'b0, 7'h7F, 8'h00, "unmapped 7F");
    checkReg(1'b0, 7'h38, 8'h00, "unmapped 38");
    checkIrq(1'b0, 1'b0, "rst irq8");
    checkIrq(1'b1, 1'b0, "rst irq16");

    $display("[TB] ch0 auto reload=3 ps=/1");
    applyStimulus(1'b0, 7'h30, 8'h03);
    applyStimulus(1'b0, 7'h32, 8'h07);
    checkReg(1'b0, 7'h32, 8'h07, "ch0 ctrl");
    checkReg(1'b0, 7'h33, 8'h0E, "ch0 stat after enable");
    waitEdges(3);
    checkReg(1'b0, 7'h33, 8'h02, "ch0 count zero");
    checkIrq(1'b0, 1'b0, "ch0 irq before underflow");
    waitEdges(1);
    checkReg(1'b0, 7'h33, 8'h0F, "ch0 first underflow");
    checkIrq(1'b0, 1'b1, "ch0 irq raised");
    applyStimulus(1'b0, 7'h33, 8'h01);
    checkReg(1'b0, 7'h33, 8'h0A, "ch0 after w1c");
    checkIrq(1'b0, 1'b0, "ch0 irq cleared");
    waitEdges(3);
    checkReg(1'b0, 7'h33, 8'h0F, "ch0 second underflow");
    waitEdges(3);
    applyStimulus(1'b0, 7'h33, 8'h01);
    checkReg(1'b0, 7'h33, 8'h0F, "ch0 w1c on underflow edge");
    applyStimulus(1'b0, 7'h32, 8'h00);
    checkReg(1'b0, 7'h33, 8'h0D, "ch0 disable freezes count");
    applyStimulus(1'b0, 7'h33, 8'h01);
    checkReg(1'b0, 7'h33, 8'h0C, "ch0 disabled cleared");
    checkIrq(1'b0, 1'b0, "ch0 irq off");

    $display("[TB] ch1 one-shot reload=2 ps=/16");
    applyStimulus(1'b0, 7'h34, 8'h02);
    applyStimulus(1'b0, 7'h36, 8'h13);
    checkReg(1'b0, 7'h36, 8'h13, "ch1 ctrl");
    checkReg(1'b0, 7'h37, 8'h0A, "ch1 stat after enable");
    waitEdges(16);
    checkReg(1'b0, 7'h37, 8'h06, "ch1 first tick");
    waitEdges(31);
    checkReg(1'b0, 7'h37, 8'h02, "ch1 before underflow");
    checkIrq(1'b0, 1'b0, "ch1 irq before underflow");
    waitEdges(1);
    checkReg(1'b0, 7'h37, 8'h01, "ch1 underflow at 48");
    checkIrq(1'b0, 1'b1, "ch1 irq raised");
    checkReg(1'b0, 7'h36, 8'h12, "ch1 en auto-cleared");
    waitEdges(64);
    checkReg(1'b0, 7'h37, 8'h01, "ch1 stays expired");
    applyStimulus(1'b0, 7'h37, 8'h01);
    checkReg(1'b0, 7'h37, 8'h00, "ch1 flag cleared");
    checkIrq(1'b0, 1'b0, "ch1 irq off");

    $display("[TB] ch0 gated ce reload=1");
    applyStimulus(1'b0, 7'h30, 8'h01);
    applyStimulus(1'b0, 7'h32, 8'h07);
    for (int i = 1; i <= 12; i++) begin
      ce8 = (i % 3 == 0);
      @(posedge clk);
      #1;
      case (i)
        5:  checkReg(1'b0, 7'h33, 8'h02, "gated before underflow");
        6:  checkReg(1'b0, 7'h33, 8'h07, "gated underflow 6");
        11: checkReg(1'b0, 7'h33, 8'h03, "gated before second");
        12: checkReg(1'b0, 7'h33, 8'h07, "gated underflow 12");
        default: ;
      endcase
    end
    ce8 = 1'b1;
    applyStimulus(1'b0, 7'h32, 8'h00);
    applyStimulus(1'b0, 7'h33, 8'h01);
    applyStimulus(1'b0, 7'h31, 8'hAB);
    checkReg(1'b0, 7'h31, 8'h00, "reload hi unused on 8-bit");
    checkReg(1'b0, 7'h30, 8'h01, "reload lo readback");

    $display("[TB] 16-bit reset mid-count");
    applyStimulus(1'b1, 7'h30, 8'h34);
    applyStimulus(1'b1, 7'h31, 8'h12);
    applyStimulus(1'b1, 7'h32, 8'h07);
    waitEdges(100);
    checkReg(1'b1, 7'h33, 8'hD2, "ch16 after 100 ticks");
    rstN16 = 1'b0;
    #1;
    checkReg(1'b1, 7'h30, 8'h00, "ch16 rst rlo");
    checkReg(1'b1, 7'h31, 8'h00, "ch16 rst rhi");
    checkReg(1'b1, 7'h32, 8'h00, "ch16 rst ctrl");
    checkReg(1'b1, 7'h33, 8'h00, "ch16 rst stat");
    checkIrq(1'b1, 1'b0, "ch16 rst irq");
    rstN16 = 1'b1;
    waitEdges(1);
    applyStimulus(1'b1, 7'h30, 8'h34);
    applyStimulus(1'b1, 7'h31, 8'h12);
    applyStimulus(1'b1, 7'h32, 8'h07);
    checkReg(1'b1, 7'h31, 8'h12, "ch16 reload hi");
    waitEdges(4660);
    checkReg(1'b1, 7'h33, 8'h02, "ch16 before period end");
    checkIrq(1'b1, 1'b0, "ch16 irq before period end");
    waitEdges(1);
    checkReg(1'b1, 7'h33, 8'h37, "ch16 underflow at 0x1235");
    checkIrq(1'b1, 1'b1, "ch16 irq raised");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_timer.md
# sys_timer

Parametrised multi-channel programmable interval timer on the CPU system-register bus. It supersedes the fixed single-divider timer registers in the 0x30–0x3A window. NUM_CH independent down-counters each have a prescaler, one-shot/auto-reload mode and a maskable, sticky interrupt flag. Each channel's interrupt request is ORed into one `irq` line to the CPU.

## Interface
- `NUM_CH`, 2: timer channel count, 1–4.
- `CNT_W`, 8: counter/reload width, 8 or 16.
- `BASE`, 7'h30: first register address; channel n occupies `BASE+4n` .. `BASE+4n+3`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce` in 1: timer time-base enable; all counting advances only on cycles with `ce`=1.
- `sys_cs` in 1: system register select.
- `cpu_rwn` in 1: 1 = read, 0 = write.
- `AB` in 7: register address.
- `din` in 8: write data.
- `dout` out 8: read data, combinational from `AB`; 8'h00 when unmapped.
- `irq` out 1: OR over channels of (flag & irq_en).

## Operation
- Write strobe is `sys_cs & ~cpu_rwn & ce`, sampled at the clk edge. Reads have no side effects.
- Per-channel registers, at offset from the channel base:
  - +0 RELOAD_LO: R/W reload[7:0].
  - +1 RELOAD_HI: R/W reload[15:8]. Unused when CNT_W=8: reads 0, writes ignored.
  - +2 CTRL, R/W:
    - bit0 en.
    - bit1 irq_en.
    - bit2 auto (1 = auto-reload, 0 = one-shot).
    - bits5:4 ps: 0=/1, 1=/16, 2=/64, 3=/256.
    - Other bits read 0.
  - +3 STAT:
    - Read: bit0 = flag, bit1 = en; bits7:2 = count[5:0] when CNT_W=8, else count[7:2].
    - Write: 1 to bit0 clears flag (W1C); other bits ignored.
- Each channel has an 8-bit prescaler counting `ce` cycles. A tick occurs when the prescaler's low k bits are all ones (k = 0, 4, 6, 8 for ps = 0..3).
- Enable, 0→1 write to `en`: count ← reload, prescaler ← 0.
- Reload write:
  - While en=0, also loads count.
  - While en=1, the new value takes effect at the next underflow.
- On a tick with en=1:
  - count≠0: count ← count−1.
  - count=0 (underflow): flag ← 1. With auto=1, count ← reload. With auto=0, en ← 0 and count stays 0.
- Reload=0 with auto=1 produces an underflow on every tick.
- Disabling (en 1→0) freezes count and prescaler. Flag is unaffected.
- Flag is sticky until cleared by W1C.
- Changing `ps` while running takes effect immediately. The prescaler is not reset.

## Timing
- Reset values: all registers, counters, prescalers and flags = 0; `irq`=0; `dout`=8'h00 when not selected.
- Register writes are visible on `dout` the cycle after the write edge.
- Flag sets on the same edge as the underflow tick. `irq` rises combinationally the following cycle.
- Period in ce-cycles, auto mode: (reload+1)·2^k.
- First underflow after enable at ps=0: reload+1 ce-cycles.
- Simultaneous events:
  - W1C to flag on the same edge as an underflow: flag ends 1 (set wins).
  - CTRL write on the same edge as a tick: the written `en` value wins. A tick with en already 1 still decrements unless the write disables.
  - Underflow in one-shot mode on the same edge as a CTRL write with en=1: the write wins, en stays 1 and count reloads.
- Asserting `reset_n` mid-count immediately clears all state.

## Structure
- Package `sys_timer_pkg`:
  - Register offsets `OFS_RLO`, `OFS_RHI`, `OFS_CTRL`, `OFS_STAT`.
  - CTRL bit positions.
  - `ps_e` enum.
  - Function mapping `ps_e` to tick-mask width.
- Sub-module `sys_timer_chan`:
  - One channel: registers, prescaler, counter, flag.
  - Inputs: decoded per-channel write strobes, din.
  - Outputs: readback bytes, irq_req.
- Top instantiates NUM_CH channels via generate and decodes `AB` against `BASE`. The read mux and the `irq` OR live in the top.

## Test plan
- Reset, then read every mapped address: all 8'h00 and `irq`=0. Unmapped address 7'h7F reads 8'h00.
- Ch0: reload=3, CTRL=8'h07 (en, irq_en, auto, ps=/1), `ce` held high:
  - flag sets every 4 cycles; `irq`=1.
  - W1C clears the flag; it re-sets 4 cycles later.
- Ch1 one-shot: reload=2, ps=/16:
  - single underflow at 48 ce-cycles.
  - en reads 0 afterwards; count stays 0; no further flags.
- Gate `ce` to every 3rd cycle with reload=1, ps=/1: underflow every 6 clk cycles.
- W1C on the exact underflow edge: flag reads 1 afterwards.
- Assert `reset_n` mid-count on CNT_W=16 with reload=16'h1234: all state 0 immediately. Re-enable reproduces the period (0x1235)·2^k exactly.
